// File: rtl/riscv_biu_mem_responder.sv
// Behavioural BIU memory target: accepts single and burst (INCR/WRAP) transfers
// into a word-organised memory with an optional fixed wait before the first beat.
package biu_pkg;
   typedef enum logic [2:0] {
      BYTE  = 3'b000,
      HWORD = 3'b001,
      WORD  = 3'b010,
      DWORD = 3'b011,
      QWORD = 3'b100
   } biu_size_t;

   typedef enum logic [2:0] {
      SINGLE = 3'b000,
      INCR   = 3'b001,
      WRAP4  = 3'b010,
      INCR4  = 3'b011,
      WRAP8  = 3'b100,
      INCR8  = 3'b101,
      WRAP16 = 3'b110,
      INCR16 = 3'b111
   } biu_type_t;

   typedef logic [2:0] biu_prot_t;
endpackage

module riscv_biu_mem_responder
   import biu_pkg::*;
#(
   parameter int               XLEN    = 32,
   parameter int               PLEN    = XLEN,
   parameter int               DEPTH   = 256,
   parameter logic [PLEN-1:0]  BASE    = '0,
   parameter int               LATENCY = 0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              biu_stb_i,
   output logic              biu_stb_ack_o,
   output logic              biu_d_ack_o,
   input  logic [PLEN-1:0]   biu_adri_i,
   output logic [PLEN-1:0]   biu_adro_o,
   input  biu_size_t         biu_size_i,
   input  biu_type_t         biu_type_i,
   input  biu_prot_t         biu_prot_i,
   input  logic              biu_lock_i,
   input  logic              biu_we_i,
   input  logic [XLEN-1:0]   biu_d_i,
   output logic [XLEN-1:0]   biu_q_o,
   output logic              biu_ack_o,
   output logic              biu_err_o
);

   localparam int NB = XLEN / 8;
   localparam int AW = $clog2(NB);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [LW-1:0]   LAT_LAST = LW'((LATENCY > 0) ? LATENCY - 1 : 0);
   localparam logic [PLEN:0]   SPAN     = (PLEN+1)'(DEPTH * NB);
   localparam logic [PLEN-1:0] STEP     = PLEN'(NB);
   localparam logic [PLEN-1:0] ADR_ONE  = {{(PLEN-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LATWAIT = 2'd1,
      BURST   = 2'd2
   } state_t;

   function automatic logic [3:0] f_last_beat(input biu_type_t t);
      case (t)
         WRAP4, INCR4:   f_last_beat = 4'd3;
         WRAP8, INCR8:   f_last_beat = 4'd7;
         WRAP16, INCR16: f_last_beat = 4'd15;
         default:        f_last_beat = 4'd0;
      endcase
   endfunction

   function automatic logic f_is_wrap(input biu_type_t t);
      case (t)
         WRAP4, WRAP8, WRAP16: f_is_wrap = 1'b1;
         default:              f_is_wrap = 1'b0;
      endcase
   endfunction

   // Address bits that may change inside a burst; all-ones means plain increment.
   function automatic logic [PLEN-1:0] f_wrap_mask(input biu_type_t t);
      logic [PLEN-1:0] n_bytes;
      n_bytes = (PLEN'(f_last_beat(t)) + ADR_ONE) << AW;
      if (f_is_wrap(t)) begin
         f_wrap_mask = n_bytes - ADR_ONE;
      end else begin
         f_wrap_mask = '1;
      end
   endfunction

   function automatic logic [NB-1:0] f_byte_en(input biu_size_t s, input logic [AW-1:0] off);
      logic [15:0] m;
      case (s)
         BYTE:    m = 16'h0001;
         HWORD:   m = 16'h0003;
         WORD:    m = 16'h000F;
         DWORD:   m = 16'h00FF;
         default: m = 16'hFFFF;
      endcase
      m = m << off;
      f_byte_en = m[NB-1:0];
   endfunction

   state_t            r_state, w_state_nxt;
   logic              w_accept, w_beat, w_in_range, w_mem_we;
   logic [PLEN-1:0]   r_adr, w_adr_inc, w_adr_nxt, r_wmask, w_rel;
   logic [PLEN:0]     w_rel_in;
   biu_size_t         r_size;
   logic              r_we, r_err, r_single;
   logic [XLEN-1:0]   r_wdata, w_wdata, w_rdata;
   logic [3:0]        r_beat, r_last;
   logic [LW-1:0]     r_lat;
   logic [NB-1:0]     w_be;
   logic [IW-1:0]     w_idx;
   logic [XLEN-1:0]   r_mem [DEPTH];
   logic              w_unused;

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic and request acceptance
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      case (r_state)
         IDLE: begin
            if (biu_stb_i) begin
               w_accept    = 1'b1;
               w_state_nxt = (LATENCY > 0) ? LATWAIT : BURST;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         LATWAIT: begin
            if (r_lat == LAT_LAST) begin
               w_state_nxt = BURST;
            end else begin
               w_state_nxt = LATWAIT;
            end
         end
         BURST: begin
            if (r_beat == r_last) begin
               w_state_nxt = IDLE;
            end else begin
               w_state_nxt = BURST;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign w_rel_in   = {1'b0, biu_adri_i} - {1'b0, BASE};
   assign w_in_range = ~w_rel_in[PLEN] && (w_rel_in < SPAN);

   assign w_adr_inc  = r_adr + STEP;
   assign w_adr_nxt  = (r_adr & ~r_wmask) | (w_adr_inc & r_wmask);

   // Transfer context latched at acceptance, advanced once per beat
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_adr    <= '0;
         r_size   <= WORD;
         r_we     <= 1'b0;
         r_err    <= 1'b0;
         r_single <= 1'b0;
         r_wdata  <= '0;
         r_beat   <= 4'd0;
         r_last   <= 4'd0;
         r_lat    <= '0;
         r_wmask  <= '1;
      end else if (w_accept) begin
         r_adr    <= biu_adri_i;
         r_size   <= biu_size_i;
         r_we     <= biu_we_i;
         r_err    <= ~w_in_range;
         r_single <= (biu_type_i == SINGLE);
         r_wdata  <= biu_d_i;
         r_beat   <= 4'd0;
         r_last   <= f_last_beat(biu_type_i);
         r_lat    <= '0;
         r_wmask  <= f_wrap_mask(biu_type_i);
      end else if (r_state == LATWAIT) begin
         r_lat    <= r_lat + LW'(1);
      end else if (r_state == BURST) begin
         r_adr    <= w_adr_nxt;
         r_beat   <= r_beat + 4'd1;
      end
   end

   // A beat is live in BURST unless reset is aborting it this very cycle.
   assign w_beat   = (r_state == BURST) && ~rst_i;
   assign w_rel    = r_adr - BASE;
   assign w_idx    = w_rel[AW +: IW];
   assign w_mem_we = w_beat && r_we && ~r_err;
   assign w_wdata  = (r_beat == 4'd0) ? r_wdata : biu_d_i;
   assign w_be     = r_single ? f_byte_en(r_size, r_adr[AW-1:0]) : '1;
   assign w_rdata  = r_mem[w_idx];

   // Byte-lane memory write; contents are deliberately never reset
   always_ff @(posedge clk_i) begin
      if (w_mem_we) begin
         for (int b = 0; b < NB; b++) begin
            if (w_be[b]) begin
               r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
            end
         end
      end
   end

   assign biu_stb_ack_o = (r_state == IDLE) && biu_stb_i && ~rst_i;
   assign biu_ack_o     = w_beat && ~r_err;
   assign biu_err_o     = w_beat && r_err;
   assign biu_d_ack_o   = w_beat && r_we && ~r_err && (r_beat != 4'd0);
   assign biu_adro_o    = w_beat ? r_adr : '0;
   assign biu_q_o       = (w_beat && ~r_we && ~r_err) ? w_rdata : '0;

   assign w_unused = ^{biu_lock_i, biu_prot_i, w_rel, w_rel_in};

endmodule

// File: doc/riscv_biu_mem_responder.md
RISCV_BIU_MEM_RESPONDER -- requirements
Module: riscv_biu_mem_responder

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning data width, 32 or 64.
REQ-002 The block SHALL have parameter PLEN, default XLEN, meaning physical address width.
REQ-003 The block SHALL have parameter DEPTH, default 256, meaning number of XLEN-bit memory words.
REQ-004 The block SHALL have parameter BASE, default 0, meaning the byte address of word 0, aligned to DEPTH*XLEN/8.
REQ-005 The block SHALL have parameter LATENCY, default 0, meaning wait cycles between strobe acknowledge and first beat.
REQ-006 The block SHALL have port clk_i, input, width 1: clock; one clock, all logic on its rising edge.
REQ-007 The block SHALL have port rst_i, input, width 1: reset, synchronous, active-high.
REQ-008 The block SHALL have port biu_stb_i, input, width 1: transfer request.
REQ-009 The block SHALL have port biu_stb_ack_o, output, width 1: request accepted.
REQ-010 The block SHALL have port biu_d_ack_o, output, width 1: write data on biu_d_i consumed; next beat wanted.
REQ-011 The block SHALL have ports biu_adri_i, input, width PLEN, start address; and biu_adro_o, output, width PLEN, current beat address.
REQ-012 The block SHALL have ports biu_size_i (biu_size_t), biu_type_i (biu_type_t), biu_prot_i (biu_prot_t) and biu_lock_i (width 1), all inputs: transfer attributes.
REQ-013 The block SHALL have ports biu_we_i, input, width 1, write enable; biu_d_i, input, width XLEN, write data; and biu_q_o, output, width XLEN, read data.
REQ-014 The block SHALL have ports biu_ack_o, output, width 1, beat complete; and biu_err_o, output, width 1, beat error.

Function
REQ-015 FSM states SHALL be IDLE, LATWAIT and BURST.
REQ-016 biu_stb_ack_o SHALL equal biu_stb_i when in IDLE (combinational, same cycle) and SHALL be 0 in every other state.
REQ-017 On acceptance the block SHALL latch adri, size, type and we, plus biu_d_i as beat-0 write data, and SHALL go to LATWAIT if LATENCY>0, else to BURST.
REQ-018 LATWAIT SHALL last exactly LATENCY cycles; the first beat therefore completes at cycle T+LATENCY+1, where T is the acceptance cycle.
REQ-019 The beat count N SHALL be 1 for SINGLE and INCR; 4 for WRAP4 and INCR4; 8 for WRAP8 and INCR8; 16 for WRAP16 and INCR16.
REQ-020 BURST SHALL complete one beat per cycle, back-to-back, asserting biu_ack_o (or biu_err_o) exactly once per beat, with N pulses in total, then return to IDLE.
REQ-021 biu_adro_o SHALL carry the address of the beat being acknowledged.
REQ-022 For INCRx, each beat address SHALL be the previous address plus XLEN/8.
REQ-023 For WRAPx, the address SHALL increment as for INCRx, but the bits above log2(N*XLEN/8) SHALL be held constant (wrap at the burst boundary).
REQ-024 Read beats: biu_q_o SHALL be mem[beat address] in the acknowledge cycle; otherwise biu_q_o SHALL be 0.
REQ-025 Write beat 0 SHALL use the latched data; beats 1..N-1 SHALL write biu_d_i and assert biu_d_ack_o in the same cycle as biu_ack_o.
REQ-026 biu_d_ack_o SHALL never be asserted for beat 0 or for reads.
REQ-027 For a SINGLE write, byte enables SHALL be derived from biu_size_i and the low address bits, with lane = address offset within the word; all other bursts SHALL write full words.
REQ-028 A transfer whose start address is outside [BASE, BASE+DEPTH*XLEN/8) SHALL assert biu_err_o instead of biu_ack_o on all N beats, with no memory write and biu_q_o = 0.
REQ-029 biu_ack_o and biu_err_o SHALL never be asserted together.
REQ-030 biu_lock_i and biu_prot_i SHALL be accepted and ignored.
REQ-031 biu_stb_i asserted outside IDLE SHALL be ignored (the initiator holds it); it SHALL be accepted in the first IDLE cycle after the burst ends.
REQ-032 Memory contents SHALL persist across bursts.
REQ-033 The beat counter and address arithmetic SHALL be unsigned, with no carry out of the wrap field.

Reset
REQ-034 While rst_i=1 the state SHALL be IDLE and biu_stb_ack_o, biu_d_ack_o, biu_ack_o and biu_err_o SHALL be 0; biu_q_o and biu_adro_o SHALL be 0.
REQ-035 Reset mid-burst SHALL abort the burst with no further acks; memory words already written SHALL be kept, and memory SHALL NOT be cleared.

Verification
REQ-036 With XLEN=32, LATENCY=2, BASE=0: a SINGLE WORD write of 0xDEADBEEF at 0x10 accepted at T -> ack at T+3; then a SINGLE read of 0x10 -> biu_q_o=0xDEADBEEF with ack.
REQ-037 With LATENCY=0: a WRAP4 read at 0x18 -> stb_ack at T, then acks at T+1..T+4 with adro 0x18, 0x1C, 0x10, 0x14.
REQ-038 A WRAP4 write at 0x08 with data A, B, C, D -> d_ack on beats 1-3 only; readback of 0x08, 0x0C, 0x00, 0x04 returns A, B, C, D.
REQ-039 A SINGLE BYTE write of 0x5A at 0x13 over word 0x11223344 -> readback 0x5A223344.
REQ-040 A WRAP4 read at 0x400 with DEPTH=256 -> 4 err pulses and 0 acks; a stb held during that burst -> stb_ack asserted only in the IDLE cycle after the 4th err.
REQ-041 rst_i asserted after beat 1 of a WRAP8 write -> no further acks; beat 0 and beat 1 data retained; next request accepted normally.
